// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a show-ahead FIFO in fixed-length bursts onto a
// valid/ready stream through a 2-entry skid buffer with registered outputs.
//
// Parameters:
//   DATA_WIDTH   - data word width
//   WORDS_AMOUNT - depth of the upstream FIFO
//   ADDR_WIDTH   - FIFO address width (fill level is ADDR_WIDTH+1 bits)
//   BURST_LEN    - words per full burst, 1..WORDS_AMOUNT
//   TIMEOUT      - idle cycles before a short burst (timeout build only)
//
// Ports:
//   clk_i             - clock
//   rst_i             - synchronous active-high reset
//   fifo_data_i       - FIFO head word, valid while fifo_empty_i is low
//   fifo_empty_i      - FIFO empty flag
//   fifo_used_words_i - FIFO fill level
//   fifo_rd_o         - FIFO read strobe, pops the head on the same edge
//   data_o            - stream data
//   valid_o           - stream valid
//   ready_i           - stream ready
//   last_o            - marks the final word of a burst
//   busy_o            - high while a burst is in progress
//
// Build option: define FIFO_BURST_READER_TIMEOUT_EN to issue a short burst
// of whatever is buffered once the FIFO has sat non-empty but below
// BURST_LEN for TIMEOUT cycles. Without it only full bursts are issued.

module fifo_burst_reader #(
    parameter int DATA_WIDTH   = 8,
    parameter int WORDS_AMOUNT = 8,
    parameter int ADDR_WIDTH   = $clog2(WORDS_AMOUNT),
    parameter int BURST_LEN    = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    input  logic                  fifo_empty_i,
    input  logic [ADDR_WIDTH:0]   fifo_used_words_i,
    output logic                  fifo_rd_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o,
    output logic                  busy_o
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);

    generate
        if (BURST_LEN < 1 || BURST_LEN > WORDS_AMOUNT || TIMEOUT < 1) begin : g_bad_param
            $error("fifo_burst_reader: illegal BURST_LEN or TIMEOUT");
        end
    endgenerate

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] word_cnt, word_cnt_nxt;
    logic [CNT_W-1:0] word_cnt_inc;
    logic [CNT_W-1:0] target, target_nxt;

    logic                  rd;
    logic                  rd_last;
    logic                  pop;
    logic [1:0]            occupancy;

    logic                  skid_valid;
    logic                  skid_last;
    logic [DATA_WIDTH-1:0] skid_data;

    assign word_cnt_inc = word_cnt + CNT_W'(1);
    assign rd_last      = (word_cnt_inc == target);
    assign pop          = valid_o && ready_i;
    assign occupancy    = {1'b0, valid_o} + {1'b0, skid_valid};

    // Reset wins even combinationally so the FIFO is never popped on the
    // reset edge; the next burst then starts from the current head.
    assign fifo_rd_o = rd && !rst_i;
    assign busy_o    = (state == BURST);

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] idle_cnt;
    logic            idle_cond;
    logic            idle_hit;

    assign idle_cond = (state == IDLE) && !fifo_empty_i
                       && (fifo_used_words_i < BURST_LEN_C);
    assign idle_hit  = idle_cond && (idle_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || !idle_cond || idle_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TO_W'(1);
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            word_cnt <= '0;
            target   <= '0;
        end else begin
            state    <= state_nxt;
            word_cnt <= word_cnt_nxt;
            target   <= target_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        word_cnt_nxt = word_cnt;
        target_nxt   = target;
        rd           = 1'b0;
        unique case (state)
            IDLE: begin
                if (fifo_used_words_i >= BURST_LEN_C) begin
                    state_nxt  = BURST;
                    target_nxt = BURST_LEN_C;
                end
`ifdef FIFO_BURST_READER_TIMEOUT_EN
                else if (idle_hit) begin
                    state_nxt  = BURST;
                    target_nxt = fifo_used_words_i;
                end
`endif
            end
            BURST: begin
                // Registered occupancy only: no path from ready_i.
                rd = !fifo_empty_i && (occupancy < 2'd2);
                if (rd) begin
                    if (rd_last) begin
                        state_nxt    = IDLE;
                        word_cnt_nxt = '0;
                    end else begin
                        word_cnt_nxt = word_cnt_inc;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output stage is the head of the skid buffer; skid holds the second
    // word. A read is only issued with occupancy < 2, so a push never
    // coincides with a full buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o     <= '0;
            valid_o    <= 1'b0;
            last_o     <= 1'b0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!valid_o || pop) begin
            if (skid_valid) begin
                data_o     <= skid_data;
                last_o     <= skid_last;
                valid_o    <= 1'b1;
                skid_valid <= 1'b0;
            end else if (rd) begin
                data_o  <= fifo_data_i;
                last_o  <= rd_last;
                valid_o <= 1'b1;
            end else begin
                valid_o <= 1'b0;
                last_o  <= 1'b0;
            end
        end else if (rd) begin
            skid_data  <= fifo_data_i;
            skid_last  <= rd_last;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed bench for fifo_burst_reader with a
// show-ahead FIFO model and a stream capture monitor.

module tb_fifo_burst_reader;

    localparam int DW = 8;
    localparam int WA = 8;
    localparam int AW = 3;
    localparam int BL = 4;
    localparam int TO = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [DW-1:0] fifo_data_i;
    logic          fifo_empty_i;
    logic [AW:0]   fifo_used_words_i;
    logic          fifo_rd_o;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i;
    logic          last_o;
    logic          busy_o;

    fifo_burst_reader #(
        .DATA_WIDTH  (DW),
        .WORDS_AMOUNT(WA),
        .ADDR_WIDTH  (AW),
        .BURST_LEN   (BL),
        .TIMEOUT     (TO)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .fifo_data_i      (fifo_data_i),
        .fifo_empty_i     (fifo_empty_i),
        .fifo_used_words_i(fifo_used_words_i),
        .fifo_rd_o        (fifo_rd_o),
        .data_o           (data_o),
        .valid_o          (valid_o),
        .ready_i          (ready_i),
        .last_o           (last_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    logic [7:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;

    assign fifo_data_i       = mem[rd_ptr[7:0]];
    assign fifo_empty_i      = (wr_ptr == rd_ptr);
    assign fifo_used_words_i = 4'(wr_ptr - rd_ptr);

    always @(posedge clk_i) begin
        if (fifo_rd_o && !fifo_empty_i) rd_ptr <= rd_ptr + 1;
    end

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    logic [7:0] cap_data [0:2047];
    logic       cap_last [0:2047];
    int         cap_cyc  [0:2047];
    int cap_n    = 0;
    int rd_cnt   = 0;
    int rd_empty = 0;

    always @(negedge clk_i) begin
        if (fifo_rd_o) begin
            rd_cnt <= rd_cnt + 1;
            if (fifo_empty_i) rd_empty <= rd_empty + 1;
        end
        if (valid_o && ready_i && !rst_i && cap_n < 2048) begin
            cap_data[cap_n] <= data_o;
            cap_last[cap_n] <= last_o;
            cap_cyc[cap_n]  <= cyc;
            cap_n           <= cap_n + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic push(input logic [7:0] v);
        mem[wr_ptr[7:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_caps(input int n, input string tag);
        for (int i = 0; i < 500 && cap_n < n; i++) step();
        check(tag, 32'(cap_n >= n), 32'd1);
    endtask

    int base;
    int r0;
    int errs;
    int pushed;
    int i;
    logic [7:0] d_hold;

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 8'h00;
        rst_i   = 1'b1;
        ready_i = 1'b0;
        step();
        step();
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_last", 32'(last_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_rd", 32'(fifo_rd_o), 32'd0);
        rst_i = 1'b0;
        step();

        // Preloaded burst at full throughput.
        ready_i = 1'b1;
        base = cap_n;
        r0 = rd_cnt;
        for (int k = 0; k < 4; k++) push(8'(8'h10 + k));
        for (int k = 0; k < 20 && rd_cnt - r0 < 4; k++) step();
        check("t1_reads", 32'(rd_cnt - r0), 32'd4);
        check("t1_busy_fall", 32'(busy_o), 32'd0);
        check("t1_rd_idle", 32'(fifo_rd_o), 32'd0);
        wait_caps(base + 4, "t1_caps");
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t1_data%0d", k), 32'(cap_data[base+k]),
                  32'(8'h10 + k));
            check($sformatf("t1_last%0d", k), 32'(cap_last[base+k]),
                  32'(k == 3));
        end
        check("t1_back2back", 32'(cap_cyc[base+3] - cap_cyc[base]), 32'd3);

`ifndef FIFO_BURST_READER_TIMEOUT_EN
        // Short fill never starts a burst.
        base = cap_n;
        r0 = rd_cnt;
        push(8'h30);
        push(8'h31);
        push(8'h32);
        repeat (100) step();
        check("t2_no_rd", 32'(rd_cnt - r0), 32'd0);
        check("t2_no_caps", 32'(cap_n - base), 32'd0);
        check("t2_valid", 32'(valid_o), 32'd0);
        push(8'h33);
        wait_caps(base + 4, "t2_caps");
        check("t2_data3", 32'(cap_data[base+3]), 32'h33);
        check("t2_last3", 32'(cap_last[base+3]), 32'd1);
        check("t2_last2", 32'(cap_last[base+2]), 32'd0);
`else
        // Short burst after the idle timeout.
        base = cap_n;
        push(8'hA0);
        push(8'hA1);
        for (i = 1; i <= 40; i++) begin
            step();
            if (busy_o) break;
        end
        check("t2_timeout", 32'(i), 32'd16);
        wait_caps(base + 2, "t2_caps");
        check("t2_data0", 32'(cap_data[base]), 32'hA0);
        check("t2_last0", 32'(cap_last[base]), 32'd0);
        check("t2_data1", 32'(cap_data[base+1]), 32'hA1);
        check("t2_last1", 32'(cap_last[base+1]), 32'd1);
`endif

        // Back-pressure in the middle of two bursts.
        repeat (3) step();
        base = cap_n;
        for (int k = 0; k < 8; k++) push(8'(k));
        wait_caps(base + 2, "t3_pre");
        ready_i = 1'b0;
        d_hold = data_o;
        repeat (5) step();
        check("t3_hold_valid", 32'(valid_o), 32'd1);
        check("t3_hold_data", 32'(data_o), 32'(d_hold));
        check("t3_rd_stop", 32'(fifo_rd_o), 32'd0);
        ready_i = 1'b1;
        wait_caps(base + 8, "t3_caps");
        repeat (10) step();
        check("t3_count", 32'(cap_n - base), 32'd8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t3_data%0d", k), 32'(cap_data[base+k]), 32'(k));
            check($sformatf("t3_last%0d", k), 32'(cap_last[base+k]),
                  32'(k == 3 || k == 7));
        end

        // Reset in the middle of a burst.
        r0 = rd_cnt;
        for (int k = 0; k < 8; k++) push(8'(8'h50 + k));
        for (int k = 0; k < 20 && rd_cnt - r0 < 2; k++) step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("t4_reads", 32'(rd_cnt - r0), 32'd2);
        check("t4_valid", 32'(valid_o), 32'd0);
        check("t4_last", 32'(last_o), 32'd0);
        check("t4_data", 32'(data_o), 32'd0);
        check("t4_busy", 32'(busy_o), 32'd0);
        check("t4_rd", 32'(fifo_rd_o), 32'd0);
        check("t4_head", 32'(fifo_data_i), 32'h52);
        base = cap_n;
        push(8'h58);
        push(8'h59);
        wait_caps(base + 8, "t4_caps");
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t4_data%0d", k), 32'(cap_data[base+k]),
                  32'(8'h52 + k));
            check($sformatf("t4_last%0d", k), 32'(cap_last[base+k]),
                  32'(k == 3 || k == 7));
        end

        // Random back-pressure with the FIFO refilled every cycle.
        repeat (5) step();
        base = cap_n;
        pushed = 0;
        for (int k = 0; k < 4000 && pushed < 400; k++) begin
            ready_i = 1'($urandom_range(0, 1));
            if (wr_ptr - rd_ptr < WA) begin
                push(8'(8'h80 + pushed));
                pushed++;
            end
            step();
        end
        ready_i = 1'b1;
        wait_caps(base + 400, "t5_caps");
        errs = 0;
        for (int k = 0; k < 400; k++) begin
            if (cap_data[base+k] !== 8'(8'h80 + k)) errs++;
            if (cap_last[base+k] !== 1'(k % 4 == 3)) errs++;
        end
        check("t5_order_last", 32'(errs), 32'd0);
        check("t5_count", 32'(cap_n - base), 32'd400);
        check("no_rd_on_empty", 32'(rd_empty), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
